// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths, the hard-wired zero
// register and the load-type encodings used by the write-back stage.
package mips_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;
    localparam int NB_CNT_DEF  = 32;

    // Register $0 always reads as zero, so writes to it are suppressed.
    localparam logic [NB_REG_DEF-1:0] REG_ZERO = '0;

    // Encodings 5..7 are unused and fall back to full-word behaviour.
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } load_type_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB bundle plus the register-bank write port of the write-back stage.
// The bypass signals exist only when WB_BYPASS_EN is defined.
interface writeback_stage_if
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_CNT  = NB_CNT_DEF
);
    // Stage control and MEM-stage results
    logic               enable_i;
    logic               flush_i;
    logic               mem_valid_i;
    logic               mem_reg_write_i;
    logic               mem_to_reg_i;
    logic               mem_link_i;
    logic               mem_halt_i;
    logic [2:0]         mem_load_type_i;
    logic [1:0]         mem_addr_lsb_i;
    logic [NB_DATA-1:0] mem_alu_result_i;
    logic [NB_DATA-1:0] mem_read_data_i;
    logic [NB_DATA-1:0] mem_link_addr_i;
    logic [NB_REG-1:0]  mem_addr_rd_i;

    // Register-bank write port and status
    logic               rw_o;
    logic [NB_REG-1:0]  addr_rw_o;
    logic [NB_DATA-1:0] data_rw_o;
    logic               wb_valid_o;
    logic               halt_o;
    logic [NB_CNT-1:0]  retired_count_o;

`ifdef WB_BYPASS_EN
    logic               byp_valid_o;
    logic [NB_REG-1:0]  byp_addr_o;
    logic [NB_DATA-1:0] byp_data_o;
`endif

    // Upstream pipeline / register bank side
    modport master (
`ifdef WB_BYPASS_EN
        input  byp_valid_o, byp_addr_o, byp_data_o,
`endif
        output enable_i, flush_i, mem_valid_i, mem_reg_write_i, mem_to_reg_i,
               mem_link_i, mem_halt_i, mem_load_type_i, mem_addr_lsb_i,
               mem_alu_result_i, mem_read_data_i, mem_link_addr_i, mem_addr_rd_i,
        input  rw_o, addr_rw_o, data_rw_o, wb_valid_o, halt_o, retired_count_o
    );

    // Write-back stage side
    modport slave (
`ifdef WB_BYPASS_EN
        output byp_valid_o, byp_addr_o, byp_data_o,
`endif
        input  enable_i, flush_i, mem_valid_i, mem_reg_write_i, mem_to_reg_i,
               mem_link_i, mem_halt_i, mem_load_type_i, mem_addr_lsb_i,
               mem_alu_result_i, mem_read_data_i, mem_link_addr_i, mem_addr_rd_i,
        output rw_o, addr_rw_o, data_rw_o, wb_valid_o, halt_o, retired_count_o
    );

endinterface

// File: rtl/load_extend.sv
// Little-endian load extraction: picks the byte/halfword addressed by the
// low address bits and sign- or zero-extends it. Misaligned halfwords are
// not trapped; address bit 0 is simply ignored for LH/LHU.
module load_extend
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic [2:0]         load_type_i,
    input  logic [1:0]         addr_lsb_i,
    input  logic [NB_DATA-1:0] raw_i,
    output logic [NB_DATA-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it according to the load type.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        byte_sel = raw_i[{addr_lsb_i, 3'b000} +: 8];
        half_sel = raw_i[{addr_lsb_i[1], 4'b0000} +: 16];
        data_o   = raw_i;
        case (load_type_i)
            LD_B:    data_o = {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {{(NB_DATA-8){1'b0}}, byte_sel};
            LD_H:    data_o = {{(NB_DATA-16){half_sel[15]}}, half_sel};
            LD_HU:   data_o = {{(NB_DATA-16){1'b0}}, half_sel};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back datapath. Drives the register
// bank write port, counts retired instructions and latches HALT.
// Optional: define WB_BYPASS_EN to add a registered copy of the write
// committed at the previous edge for the forwarding unit.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_CNT  = NB_CNT_DEF
) (
    input  logic             clock_i,
    input  logic             reset_i,
    writeback_stage_if.slave wb
);

    logic               valid_q,      valid_d;
    logic               reg_write_q,  reg_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               link_q,       link_d;
    logic [2:0]         load_type_q,  load_type_d;
    logic [1:0]         addr_lsb_q,   addr_lsb_d;
    logic [NB_DATA-1:0] alu_q,        alu_d;
    logic [NB_DATA-1:0] raw_q,        raw_d;
    logic [NB_DATA-1:0] link_addr_q,  link_addr_d;
    logic [NB_REG-1:0]  rd_q,         rd_d;
    logic               halt_q,       halt_d;
    logic [NB_CNT-1:0]  count_q,      count_d;

    logic [NB_DATA-1:0] load_data;
    logic [NB_DATA-1:0] wb_data;
    logic               rw;

    // Next-state: reset > halt > flush > enable; otherwise everything holds.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        link_d       = link_q;
        load_type_d  = load_type_q;
        addr_lsb_d   = addr_lsb_q;
        alu_d        = alu_q;
        raw_d        = raw_q;
        link_addr_d  = link_addr_q;
        rd_d         = rd_q;
        halt_d       = halt_q;
        count_d      = count_q;
        if (halt_q) begin
            valid_d = 1'b0;
        end else if (wb.flush_i) begin
            valid_d = 1'b0;
        end else if (wb.enable_i) begin
            valid_d      = wb.mem_valid_i;
            reg_write_d  = wb.mem_reg_write_i;
            mem_to_reg_d = wb.mem_to_reg_i;
            link_d       = wb.mem_link_i;
            load_type_d  = wb.mem_load_type_i;
            addr_lsb_d   = wb.mem_addr_lsb_i;
            alu_d        = wb.mem_alu_result_i;
            raw_d        = wb.mem_read_data_i;
            link_addr_d  = wb.mem_link_addr_i;
            rd_d         = wb.mem_addr_rd_i;
            if (wb.mem_valid_i) begin
                count_d = count_q + NB_CNT'(1);
                halt_d  = wb.mem_halt_i;
            end
        end
    end

    // MEM/WB register bank with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            load_type_q  <= '0;
            addr_lsb_q   <= '0;
            alu_q        <= '0;
            raw_q        <= '0;
            link_addr_q  <= '0;
            rd_q         <= '0;
            halt_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            link_q       <= link_d;
            load_type_q  <= load_type_d;
            addr_lsb_q   <= addr_lsb_d;
            alu_q        <= alu_d;
            raw_q        <= raw_d;
            link_addr_q  <= link_addr_d;
            rd_q         <= rd_d;
            halt_q       <= halt_d;
            count_q      <= count_d;
        end
    end

    load_extend #(.NB_DATA(NB_DATA)) u_load_extend (
        .load_type_i (load_type_q),
        .addr_lsb_i  (addr_lsb_q),
        .raw_i       (raw_q),
        .data_o      (load_data)
    );

    // Write-data select: link beats load, load beats ALU result.
    always_comb begin
        wb_data = alu_q;
        if (link_q) begin
            wb_data = link_addr_q;
        end else if (mem_to_reg_q) begin
            wb_data = load_data;
        end
    end

    assign rw = valid_q & reg_write_q & (rd_q != NB_REG'(REG_ZERO));

    assign wb.rw_o            = rw;
    assign wb.addr_rw_o       = rd_q;
    assign wb.data_rw_o       = wb_data;
    assign wb.wb_valid_o      = valid_q;
    assign wb.halt_o          = halt_q;
    assign wb.retired_count_o = count_q;

`ifdef WB_BYPASS_EN
    logic               byp_valid_q;
    logic [NB_REG-1:0]  byp_addr_q;
    logic [NB_DATA-1:0] byp_data_q;

    // Remember the write the register bank commits at this edge.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            byp_valid_q <= 1'b0;
            byp_addr_q  <= '0;
            byp_data_q  <= '0;
        end else begin
            byp_valid_q <= rw;
            byp_addr_q  <= rd_q;
            byp_data_q  <= wb_data;
        end
    end

    assign wb.byp_valid_o = byp_valid_q;
    assign wb.byp_addr_o  = byp_addr_q;
    assign wb.byp_data_o  = byp_data_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected write-port values are queued
// when each capture is driven and compared one edge later.
module tb_writeback_stage;
    import mips_pkg::*;

    localparam logic [31:0] RAW = 32'h80FF7F01;

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        valid;
        logic        care;   // addr/data defined for this slot
    } wb_exp_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   n_errors = 0;
    int   n_checks = 0;
    wb_exp_t sb_q[$];

    always #5 clock_i = ~clock_i;

    writeback_stage_if wb_if ();

    writeback_stage dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wb      (wb_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic fl, input logic val, input logic rwr,
                         input logic to_reg, input logic lnk, input logic hlt,
                         input logic [2:0] lt, input logic [1:0] lsb,
                         input logic [31:0] alu, input logic [31:0] raw,
                         input logic [31:0] la, input logic [4:0] rd);
        wb_if.enable_i         = en;
        wb_if.flush_i          = fl;
        wb_if.mem_valid_i      = val;
        wb_if.mem_reg_write_i  = rwr;
        wb_if.mem_to_reg_i     = to_reg;
        wb_if.mem_link_i       = lnk;
        wb_if.mem_halt_i       = hlt;
        wb_if.mem_load_type_i  = lt;
        wb_if.mem_addr_lsb_i   = lsb;
        wb_if.mem_alu_result_i = alu;
        wb_if.mem_read_data_i  = raw;
        wb_if.mem_link_addr_i  = la;
        wb_if.mem_addr_rd_i    = rd;
    endtask

    task automatic check_wb(input string tag);
        wb_exp_t e;
        check({tag, ".sb"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check({tag, ".rw"},    32'(wb_if.rw_o),       32'(e.rw));
        check({tag, ".valid"}, 32'(wb_if.wb_valid_o), 32'(e.valid));
        if (e.care) begin
            check({tag, ".addr"}, 32'(wb_if.addr_rw_o), 32'(e.addr));
            check({tag, ".data"}, wb_if.data_rw_o,      e.data);
        end
    endtask

    // One clocked step: drive at negedge, queue the expectation, sample #1 after posedge.
    task automatic step(input string tag, input logic en, input logic fl, input logic val,
                        input logic rwr, input logic to_reg, input logic lnk, input logic hlt,
                        input logic [2:0] lt, input logic [1:0] lsb,
                        input logic [31:0] alu, input logic [31:0] raw,
                        input logic [31:0] la, input logic [4:0] rd,
                        input logic e_rw, input logic [4:0] e_addr,
                        input logic [31:0] e_data, input logic e_valid, input logic e_care);
        @(negedge clock_i);
        drive(en, fl, val, rwr, to_reg, lnk, hlt, lt, lsb, alu, raw, la, rd);
        sb_q.push_back('{rw: e_rw, addr: e_addr, data: e_data, valid: e_valid, care: e_care});
        @(posedge clock_i);
        #1;
        check_wb(tag);
    endtask

    task automatic check_status(input string tag, input logic e_halt, input logic [31:0] e_cnt);
        check({tag, ".halt"},  32'(wb_if.halt_o),  32'(e_halt));
        check({tag, ".count"}, wb_if.retired_count_o, e_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, LD_W, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);

        // Reset held for three cycles
        reset_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #1;
        check("rst.rw",    32'(wb_if.rw_o),       32'd0);
        check("rst.addr",  32'(wb_if.addr_rw_o),  32'd0);
        check("rst.data",  wb_if.data_rw_o,       32'd0);
        check("rst.valid", 32'(wb_if.wb_valid_o), 32'd0);
        check_status("rst", 1'b0, 32'd0);
`ifdef WB_BYPASS_EN
        check("rst.byp_valid", 32'(wb_if.byp_valid_o), 32'd0);
        check("rst.byp_data",  wb_if.byp_data_o,       32'd0);
`endif
        @(negedge clock_i);
        reset_i = 1'b1;

        // ALU write
        step("alu5", 1, 0, 1, 1, 0, 0, 0, LD_W, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5,
             1, 5'd5, 32'hDEADBEEF, 1, 1);
        check_status("alu5", 1'b0, 32'd1);

        // Load extraction from 0x80FF7F01
        step("lb3",  1, 0, 1, 1, 1, 0, 0, LD_B,  2'd3, 32'h11111111, RAW, 32'h0, 5'd10,
             1, 5'd10, 32'hFFFFFF80, 1, 1);
        step("lbu1", 1, 0, 1, 1, 1, 0, 0, LD_BU, 2'd1, 32'h11111111, RAW, 32'h0, 5'd11,
             1, 5'd11, 32'h0000007F, 1, 1);
        step("lh2",  1, 0, 1, 1, 1, 0, 0, LD_H,  2'd2, 32'h11111111, RAW, 32'h0, 5'd12,
             1, 5'd12, 32'hFFFF80FF, 1, 1);
        step("lhu0", 1, 0, 1, 1, 1, 0, 0, LD_HU, 2'd0, 32'h11111111, RAW, 32'h0, 5'd13,
             1, 5'd13, 32'h00007F01, 1, 1);
        step("lw",   1, 0, 1, 1, 1, 0, 0, LD_W,  2'd2, 32'h11111111, RAW, 32'h0, 5'd14,
             1, 5'd14, RAW, 1, 1);
        step("lt7",  1, 0, 1, 1, 1, 0, 0, 3'd7,  2'd1, 32'h11111111, RAW, 32'h0, 5'd15,
             1, 5'd15, RAW, 1, 1);
        step("lh3",  1, 0, 1, 1, 1, 0, 0, LD_H,  2'd3, 32'h11111111, RAW, 32'h0, 5'd16,
             1, 5'd16, 32'hFFFF80FF, 1, 1);
        step("lbu0", 1, 0, 1, 1, 1, 0, 0, LD_BU, 2'd0, 32'h11111111, 32'h000000F0, 32'h0, 5'd17,
             1, 5'd17, 32'h000000F0, 1, 1);
        check_status("loads", 1'b0, 32'd9);

        // $0 suppression and link data
        step("r0",   1, 0, 1, 1, 0, 0, 0, LD_W, 2'd0, 32'h00005555, 32'h0, 32'h0, 5'd0,
             0, 5'd0, 32'h00005555, 1, 1);
        step("jal",  1, 0, 1, 1, 0, 1, 0, LD_W, 2'd0, 32'h0000AAAA, RAW, 32'h00000048, 5'd31,
             1, 5'd31, 32'h00000048, 1, 1);
        step("jalr", 1, 0, 1, 1, 1, 1, 0, LD_B, 2'd0, 32'h0000AAAA, RAW, 32'h00000100, 5'd30,
             1, 5'd30, 32'h00000100, 1, 1);
        check_status("link", 1'b0, 32'd12);

        // Stall: inputs change (even a HALT) but the stage holds
        for (int i = 0; i < 4; i++) begin
            step("stall", 0, 0, 1, 1, 0, 0, 1, LD_B, 2'd3, 32'hCAFE0000 + 32'(i), RAW, 32'h0, 5'd7,
                 1, 5'd30, 32'h00000100, 1, 1);
            check_status("stall", 1'b0, 32'd12);
        end

        // Flush with and without enable; then an invalid slot
        step("flush_en0", 0, 1, 1, 1, 0, 0, 0, LD_W, 2'd0, 32'h77, 32'h0, 32'h0, 5'd7,
             0, 5'd0, 32'h0, 0, 0);
        check_status("flush_en0", 1'b0, 32'd12);
        step("flush_en1", 1, 1, 1, 1, 0, 0, 1, LD_W, 2'd0, 32'h77, 32'h0, 32'h0, 5'd7,
             0, 5'd0, 32'h0, 0, 0);
        check_status("flush_en1", 1'b0, 32'd12);
        step("bubble", 1, 0, 0, 1, 0, 0, 0, LD_W, 2'd0, 32'h77, 32'h0, 32'h0, 5'd6,
             0, 5'd6, 32'h77, 0, 1);
        check_status("bubble", 1'b0, 32'd12);

        // Asynchronous reset in the middle of a cycle discards the write
        step("pre_rst", 1, 0, 1, 1, 0, 0, 0, LD_W, 2'd0, 32'h8888, 32'h0, 32'h0, 5'd8,
             1, 5'd8, 32'h8888, 1, 1);
        #2;
        reset_i = 1'b0;
        #1;
        check("midrst.rw",    32'(wb_if.rw_o),       32'd0);
        check("midrst.valid", 32'(wb_if.wb_valid_o), 32'd0);
        check("midrst.data",  wb_if.data_rw_o,       32'd0);
        check_status("midrst", 1'b0, 32'd0);
        @(negedge clock_i);
        drive(0, 0, 0, 0, 0, 0, 0, LD_W, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        reset_i = 1'b1;

        // Halt after six retired instructions
        for (int i = 1; i <= 6; i++) begin
            step("pre_halt", 1, 0, 1, 1, 0, 0, 0, LD_W, 2'd0, 32'(i * 16), 32'h0, 32'h0, 5'(i),
                 1, 5'(i), 32'(i * 16), 1, 1);
        end
        check_status("pre_halt", 1'b0, 32'd6);
        step("halt", 1, 0, 1, 0, 0, 0, 1, LD_W, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0,
             0, 5'd0, 32'h0, 1, 1);
        check_status("halt", 1'b1, 32'd7);
        for (int i = 0; i < 3; i++) begin
            step("halted", 1, 0, 1, 1, 0, 0, 0, LD_W, 2'd0, 32'h9999, 32'h0, 32'h0, 5'd9,
                 0, 5'd0, 32'h0, 0, 0);
            check_status("halted", 1'b1, 32'd7);
        end
        @(negedge clock_i);
        reset_i = 1'b0;
        #1;
        check_status("halt_rst", 1'b0, 32'd0);
        check("halt_rst.rw", 32'(wb_if.rw_o), 32'd0);
        @(negedge clock_i);
        reset_i = 1'b1;

`ifdef WB_BYPASS_EN
        // Bypass copy of the write committed at the previous edge
        step("byp_wr", 1, 0, 1, 1, 0, 0, 0, LD_W, 2'd0, 32'h00001234, 32'h0, 32'h0, 5'd9,
             1, 5'd9, 32'h00001234, 1, 1);
        check("byp_wr.byp_valid", 32'(wb_if.byp_valid_o), 32'd0);
        step("byp_idle1", 1, 0, 0, 0, 0, 0, 0, LD_W, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0,
             0, 5'd0, 32'h0, 0, 1);
        check("byp.valid", 32'(wb_if.byp_valid_o), 32'd1);
        check("byp.addr",  32'(wb_if.byp_addr_o),  32'd9);
        check("byp.data",  wb_if.byp_data_o,       32'h00001234);
        step("byp_idle2", 1, 0, 0, 0, 0, 0, 0, LD_W, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0,
             0, 5'd0, 32'h0, 0, 1);
        check("byp.drop", 32'(wb_if.byp_valid_o), 32'd0);
`endif

        check("sb.drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
